// File: rtl/instr_mem_ctrl.sv
// Writable instruction memory with a registered fetch port, a program-loader port
// and an optional post-reset NOP sweep. Fetches are one-cycle synchronous reads.
module instr_mem_ctrl #(
   parameter int unsigned       ADDR_W         = 6,
   parameter int unsigned       DATA_W         = 32,
   parameter logic [DATA_W-1:0] NOP_WORD       = 32'h00000033,
   parameter bit                CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [31:0]       req_pc,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_instr,
   output logic              resp_fault,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   output logic              init_done
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_e;

   localparam state_e RST_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                resp_valid_q, resp_valid_d;
   logic                resp_fault_q, resp_fault_d;
   logic [DATA_W-1:0]   resp_instr_q, resp_instr_d;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic                run;
   logic                accept;
   logic                fault;
   logic [ADDR_W-1:0]   req_idx;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [DATA_W-1:0]   mem_wdata;

   // Decode: out-of-range addresses fault instead of aliasing onto the array.
   assign run     = (state_q == ST_RUN);
   assign req_idx = req_pc[ADDR_W+1:2];
   assign fault   = (req_pc[1:0] != 2'b00) || (req_pc[31:ADDR_W+2] != '0);

   assign ld_ready  = run;
   assign init_done = run;
   assign req_ready = run && !ld_en && (!resp_valid_q || resp_ready);
   assign accept    = req_valid && req_ready;

   // Single write port shared by the fill sweep and the loader.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no
      // path leaves it unassigned and no latch is inferred.
      mem_we    = 1'b0;
      mem_waddr = cnt_q;
      mem_wdata = NOP_WORD;
      if (state_q == ST_INIT) begin
         mem_we = 1'b1;
      end else if (ld_en) begin
         mem_we    = 1'b1;
         mem_waddr = ld_addr;
         mem_wdata = ld_data;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_INIT) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == '1) begin
            state_d = ST_RUN;
         end
      end
   end

   // A new accept overwrites the buffer in the same edge the old entry drains.
   always_comb begin
      resp_valid_d = resp_valid_q;
      resp_fault_d = resp_fault_q;
      resp_instr_d = resp_instr_q;
      if (accept) begin
         resp_valid_d = 1'b1;
         resp_fault_d = fault;
         resp_instr_d = fault ? NOP_WORD : mem[req_idx];
      end else if (resp_ready) begin
         resp_valid_d = 1'b0;
         resp_fault_d = 1'b0;
         resp_instr_d = NOP_WORD;
      end
   end

   // NOTE: the array has no reset branch; it is initialised by the fill sweep
   // (or by the loader), which keeps it mappable onto plain RAM.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RST_STATE;
         cnt_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_fault_q <= 1'b0;
         resp_instr_q <= NOP_WORD;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         resp_valid_q <= resp_valid_d;
         resp_fault_q <= resp_fault_d;
         resp_instr_q <= resp_instr_d;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_fault = resp_fault_q;
   assign resp_instr = resp_instr_q;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Scoreboard bench for instr_mem_ctrl: directed scenarios plus a random phase,
// checked against a word-array reference model of the fetch/load rules.
module tb_instr_mem_ctrl;

   localparam int          ADDR_W = 6;
   localparam int          DEPTH  = 64;
   localparam logic [31:0] NOP    = 32'h00000033;

   logic              clk;
   logic              rst_n;
   logic              req_valid;
   logic              req_ready;
   logic [31:0]       req_pc;
   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_instr;
   logic              resp_fault;
   logic              ld_en;
   logic [ADDR_W-1:0] ld_addr;
   logic [31:0]       ld_data;
   logic              ld_ready;
   logic              init_done;

   instr_mem_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(32), .NOP_WORD(NOP), .CLEAR_ON_RESET(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_instr(resp_instr), .resp_fault(resp_fault),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .ld_ready(ld_ready), .init_done(init_done)
   );

   typedef struct {
      logic [31:0] instr;
      logic        fault;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mem_m [DEPTH];
   int          checks = 0;
   int          errors = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t model_fetch(input logic [31:0] pc);
      exp_t e;
      if (pc[1:0] != 2'b00 || pc >= 32'(DEPTH * 4)) begin
         e.instr = NOP;
         e.fault = 1'b1;
      end else begin
         e.instr = mem_m[pc[ADDR_W+1:2]];
         e.fault = 1'b0;
      end
      return e;
   endfunction

   // Scoreboard: compare/pop the oldest expectation, then record new accepts.
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
         for (int i = 0; i < DEPTH; i++) mem_m[i] = NOP;
      end else begin
         if (resp_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
               check("resp_instr", resp_instr, exp_q[0].instr);
               check("resp_fault", 32'(resp_fault), 32'(exp_q[0].fault));
               if (resp_ready) void'(exp_q.pop_front());
            end
         end
         if (req_valid && req_ready) exp_q.push_back(model_fetch(req_pc));
         if (ld_en && ld_ready) mem_m[ld_addr] = ld_data;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] pc);
      int n = 0;
      req_valid = 1'b1;
      req_pc    = pc;
      #1;
      while (!req_ready && n < 50) begin
         step();
         n++;
      end
      if (!req_ready) check("fetch_timeout", 32'(req_ready), 32'd1);
      step();
      req_valid = 1'b0;
   endtask

   task automatic load(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      ld_en   = 1'b1;
      ld_addr = a;
      ld_data = d;
      step();
      ld_en = 1'b0;
   endtask

   task automatic wait_init(input string name);
      int n = 0;
      do begin
         step();
         n++;
      end while (!init_done && n < 200);
      check(name, n, 64);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_pc = '0; resp_ready = 1'b0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      repeat (3) step();

      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_fault", 32'(resp_fault), 32'd0);
      check("rst_resp_instr", resp_instr, NOP);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_ld_ready", 32'(ld_ready), 32'd0);
      check("rst_init_done", 32'(init_done), 32'd0);

      rst_n = 1'b1;
      wait_init("init_cycles");
      check("ld_ready_run", 32'(ld_ready), 32'd1);

      resp_ready = 1'b1;
      fetch(32'h0FC);
      check("fill_nop", resp_instr, NOP);
      step();

      load(6'd0, 32'h00002083);
      load(6'd1, 32'h00402103);

      req_valid = 1'b1; req_pc = 32'h0;
      step();
      check("b2b_valid0", 32'(resp_valid), 32'd1);
      check("b2b_instr0", resp_instr, 32'h00002083);
      req_pc = 32'h4;
      step();
      check("b2b_valid1", 32'(resp_valid), 32'd1);
      check("b2b_instr1", resp_instr, 32'h00402103);
      req_valid = 1'b0;
      step();

      resp_ready = 1'b0;
      req_valid  = 1'b1; req_pc = 32'h0;
      step();
      req_pc = 32'h4;
      for (int i = 0; i < 3; i++) begin
         check("bp_req_ready", 32'(req_ready), 32'd0);
         check("bp_valid", 32'(resp_valid), 32'd1);
         check("bp_instr", resp_instr, 32'h00002083);
         step();
      end
      resp_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(req_ready), 32'd1);
      step();
      check("bp_second_instr", resp_instr, 32'h00402103);
      req_valid = 1'b0;
      step();

      fetch(32'h002);
      check("fault_misaligned", 32'(resp_fault), 32'd1);
      fetch(32'h100);
      check("fault_range", 32'(resp_fault), 32'd1);
      check("fault_range_nop", resp_instr, NOP);
      fetch(32'h0FC);
      check("nofault_top", 32'(resp_fault), 32'd0);
      fetch(32'h8000_0000);
      step();

      ld_en = 1'b1; ld_addr = 6'd5; ld_data = 32'h00208233;
      req_valid = 1'b1; req_pc = 32'h14;
      #1;
      check("ld_blocks_fetch", 32'(req_ready), 32'd0);
      step();
      ld_en = 1'b0;
      #1;
      check("fetch_after_ld_ready", 32'(req_ready), 32'd1);
      step();
      req_valid = 1'b0;
      check("raw_after_ld", resp_instr, 32'h00208233);
      step();

      for (int c = 0; c < 400; c++) begin
         int r;
         ld_en      = ($urandom_range(99) < 20);
         ld_addr    = 6'($urandom_range(63));
         ld_data    = $urandom;
         req_valid  = ($urandom_range(99) < 60);
         resp_ready = ($urandom_range(99) < 70);
         r = $urandom_range(9);
         if (r < 7)       req_pc = 32'($urandom_range(63)) << 2;
         else if (r == 7) req_pc = (32'($urandom_range(63)) << 2) | 32'($urandom_range(3, 1));
         else if (r == 8) req_pc = 32'h100 + (32'($urandom_range(1000)) << 2);
         else             req_pc = $urandom;
         step();
      end

      req_valid = 1'b0; ld_en = 1'b0; resp_ready = 1'b1;
      repeat (3) step();
      check("drain_queue", exp_q.size(), 0);
      check("drain_valid", 32'(resp_valid), 32'd0);

      resp_ready = 1'b0;
      req_valid  = 1'b1; req_pc = 32'h0;
      step();
      req_valid = 1'b0;
      check("pre_rst_valid", 32'(resp_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(resp_valid), 32'd0);
      check("async_rst_done", 32'(init_done), 32'd0);
      step();
      rst_n = 1'b1;
      wait_init("reinit_cycles");
      resp_ready = 1'b1;
      fetch(32'h0);
      check("reinit_word0", resp_instr, NOP);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
- Parametrised, writable instruction memory with a registered fetch port and a program-loader port; successor to the fixed 64x32 combinational instruction ROM.
- Sits between the fetch stage (PC in, instruction out via valid/ready) and the testbench or boot loader, which writes program words after reset.
- Adds synchronous read, backpressure, fault detection and a post-reset NOP-fill sequence.

Parameters:
- ADDR_W, 6, word-address width; depth = 2**ADDR_W words.
- DATA_W, 32, instruction width.
- NOP_WORD, 32'h00000033, fill/fault instruction (add x0,x0,x0).
- CLEAR_ON_RESET, 1, 1 = sweep-fill memory with NOP_WORD after reset; 0 = skip the fill.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  fetch request accepted when req_valid && req_ready.
- req_pc  in  32  byte address of the instruction.
- resp_valid  out  1  response holds a fetched instruction.
- resp_ready  in  1  consumer accepts the response.
- resp_instr  out  DATA_W  fetched instruction, or NOP_WORD on fault.
- resp_fault  out  1  request was misaligned or out of range.
- ld_en  in  1  loader write strobe.
- ld_addr  in  ADDR_W  loader word address.
- ld_data  in  DATA_W  loader write data.
- ld_ready  out  1  loader writes are honoured when ld_en && ld_ready.
- init_done  out  1  high once the memory is usable.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n).
- Reset values: resp_valid=0, resp_fault=0, resp_instr=NOP_WORD, req_ready=0, ld_ready=0, init_done=0. The fill counter and state go to INIT, or to RUN when CLEAR_ON_RESET=0. Memory contents are not reset directly.
- State INIT:
  - Writes NOP_WORD to word cnt each cycle, cnt counting 0..2**ADDR_W-1.
  - After writing the last word, moves to RUN. INIT lasts exactly 2**ADDR_W cycles.
  - req_ready=0 and ld_ready=0; ld_en is ignored.
- State RUN:
  - init_done=1 and ld_ready=1.
  - req_ready = !ld_en && (!resp_valid || resp_ready).
  - No exit except reset.
- Loader priority: a loader write in RUN takes the single memory port, so no fetch is accepted that cycle. A fetch to the same address accepted on the next cycle returns the new data.
- Fetch latency: a request accepted at edge N gives resp_valid=1 with data after edge N, i.e. one cycle (synchronous read).
- Decode:
  - word index = req_pc[ADDR_W+1:2].
  - fault = (req_pc[1:0]!=0) || (req_pc[31:ADDR_W+2]!=0).
  - On fault: resp_instr=NOP_WORD and resp_fault=1; memory content is irrelevant.
- Response buffer (one entry):
  - Holds instr/fault stable while resp_valid && !resp_ready.
  - Cleared when resp_ready && no new accept.
  - Back-to-back fetch with resp_ready=1 gives one instruction per cycle.
- Simultaneous resp_ready and new accept: the new response replaces the old one in the same edge; no bubble.
- Reset mid-operation: any pending response is dropped immediately (asynchronous). With CLEAR_ON_RESET=1 the memory is refilled, so the program must be reloaded.
- Wrap-around: none. Addresses beyond the depth fault and are never aliased.

Test Plan:
- Reset, CLEAR_ON_RESET=1, ADDR_W=6: init_done rises exactly 64 cycles after rst_n deasserts. Then fetching pc=0x0FC returns 32'h00000033 with fault=0.
- Load word 0 = 32'h00002083 (lw x1,0(x0)) and word 1 = 32'h00402103, then fetch pc 0,4 back-to-back with resp_ready=1: responses appear on consecutive cycles 1 cycle after each accept, with correct data.
- Backpressure: hold resp_ready=0 for 3 cycles after a fetch of pc 0. resp_instr stays 32'h00002083, req_ready=0, no second request is lost. Release: the next request is accepted on the same edge.
- Fetch pc=0x002 gives fault=1 with NOP. Fetch pc=0x100 (ADDR_W=6) gives fault=1 with NOP. Fetch pc=0x0FC gives fault=0.
- ld_en and req_valid asserted together at word 5 with new data 32'h00208233: req_ready=0 that cycle. The fetch accepted next cycle returns 32'h00208233.
- Assert rst_n=0 while resp_valid=1 and resp_ready=0: resp_valid drops without a clock edge. After release, INIT repeats and word 0 reads NOP.
